// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the 16-bit RISC control unit and its execution datapath.
// ALU operation codes and the opcode range decoded by the control unit.
package cpu_defs_pkg;

  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_INC  = 4'b0010;
  localparam logic [3:0] ALU_DEC  = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0101;
  localparam logic [3:0] ALU_SHR  = 4'b0110;
  localparam logic [3:0] ALU_SHL  = 4'b0111;

  // Opcode space owned by the control unit: 7'h70..7'h7f.
  localparam logic [6:0] OPC_FIRST = 7'h70;
  localparam logic [6:0] OPC_LAST  = 7'h7f;

  function automatic logic is_cu_opcode(input logic [6:0] opc);
    return (opc >= OPC_FIRST) && (opc <= OPC_LAST);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational 16-bit ALU with a 17-bit internal result for carry/borrow.
// upd_flags marks the operations that are allowed to change N/Z/C.
module cpu_alu
  import cpu_defs_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  alu_op,
  output logic [15:0] y,
  output logic        c,
  output logic        upd_flags
);

  logic [16:0] res;

  always_comb begin
    res       = {1'b0, a};
    upd_flags = 1'b0;
    unique case (alu_op)
      ALU_INC: begin
        res       = {1'b0, a} + 17'd1;
        upd_flags = 1'b1;
      end
      ALU_DEC: begin
        // Borrow out of bit 16 is set exactly when a == 0.
        res       = {1'b0, a} - 17'd1;
        upd_flags = 1'b1;
      end
      ALU_ADD: begin
        res       = {1'b0, a} + {1'b0, b};
        upd_flags = 1'b1;
      end
      ALU_SUB: begin
        res       = {1'b0, a} - {1'b0, b};
        upd_flags = 1'b1;
      end
      ALU_SHR: begin
        res       = {a[0], 1'b0, a[15:1]};
        upd_flags = 1'b1;
      end
      ALU_SHL: begin
        res       = {a[15], a[14:0], 1'b0};
        upd_flags = 1'b1;
      end
      default: res = {1'b0, a};
    endcase
  end

  assign y = res[15:0];
  assign c = res[16];

endmodule

// File: rtl/cpu_execution_unit.sv
// Execution datapath: PC, IR, 8x16 register file, ALU and N/Z/C flags.
// Every control word completes in the cycle it is presented.
module cpu_execution_unit
  import cpu_defs_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  W_Adr,
  input  logic [2:0]  R_Adr,
  input  logic [2:0]  S_Adr,
  input  logic        adr_sel,
  input  logic        s_sel,
  input  logic        pc_ld,
  input  logic        pc_inc,
  input  logic        pc_sel,
  input  logic        ir_ld,
  input  logic        mw_en,
  input  logic        rw_en,
  input  logic [3:0]  alu_op,
  input  logic [15:0] mem_rdata,
  output logic [15:0] IR,
  output logic        N,
  output logic        Z,
  output logic        C,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic [15:0] pc
);

  logic [15:0] regs_q [8];
  logic [15:0] pc_q, pc_d, ir_q;
  logic        n_q, z_q, c_q;

  logic [15:0] r_data, s_data, wr_data;
  logic [15:0] alu_y, pc_rel, pc_tgt;
  logic        alu_c, upd_flags;

  assign r_data = regs_q[R_Adr];
  assign s_data = regs_q[S_Adr];

  cpu_alu u_alu (
    .a        (r_data),
    .b        (s_data),
    .alu_op   (alu_op),
    .y        (alu_y),
    .c        (alu_c),
    .upd_flags(upd_flags)
  );

  assign wr_data = s_sel ? mem_rdata : alu_y;

  // Relative jumps use the sign-extended 9-bit IR offset; wraps modulo 2^16.
  assign pc_rel = pc_q + {{7{ir_q[8]}}, ir_q[8:0]};
  assign pc_tgt = pc_sel ? r_data : pc_rel;

  always_comb begin
    pc_d = pc_q;
    if (pc_ld) begin
      pc_d = pc_tgt;
    end else if (pc_inc) begin
      pc_d = pc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 16'h0000;
      end
    end else if (rw_en) begin
      regs_q[W_Adr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      ir_q <= 16'h0000;
      n_q  <= 1'b0;
      z_q  <= 1'b0;
      c_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (ir_ld) begin
        ir_q <= mem_rdata;
      end
      if (upd_flags) begin
        n_q <= alu_y[15];
        z_q <= (alu_y == 16'h0000);
        c_q <= alu_c;
      end
    end
  end

  assign IR        = ir_q;
  assign N         = n_q;
  assign Z         = z_q;
  assign C         = c_q;
  assign pc        = pc_q;
  assign mem_addr  = adr_sel ? r_data : pc_q;
  assign mem_wdata = s_data;
  assign mem_we    = mw_en;

endmodule

// File: tb/tb_cpu_execution_unit.sv
// Directed bench for cpu_execution_unit: a vector table of single-cycle control
// words plus hand-written sequences for store, no-bypass and asynchronous reset.
module tb_cpu_execution_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  W_Adr, R_Adr, S_Adr;
  logic        adr_sel, s_sel, pc_ld, pc_inc, pc_sel, ir_ld, mw_en, rw_en;
  logic [3:0]  alu_op;
  logic [15:0] mem_rdata;
  logic [15:0] IR, mem_addr, mem_wdata, pc;
  logic        N, Z, C, mem_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_execution_unit #(.RESET_PC(16'h0000)) dut (
    .clk      (clk),
    .reset    (reset),
    .W_Adr    (W_Adr),
    .R_Adr    (R_Adr),
    .S_Adr    (S_Adr),
    .adr_sel  (adr_sel),
    .s_sel    (s_sel),
    .pc_ld    (pc_ld),
    .pc_inc   (pc_inc),
    .pc_sel   (pc_sel),
    .ir_ld    (ir_ld),
    .mw_en    (mw_en),
    .rw_en    (rw_en),
    .alu_op   (alu_op),
    .mem_rdata(mem_rdata),
    .IR       (IR),
    .N        (N),
    .Z        (Z),
    .C        (C),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .pc       (pc)
  );

  typedef struct {
    logic [2:0]  w, r, s;
    logic        s_sel, pc_ld, pc_inc, pc_sel, ir_ld, rw_en;
    logic [3:0]  op;
    logic [15:0] rd;
    logic [2:0]  chk;
    logic [15:0] e_pc, e_ir;
    logic [2:0]  e_nzc;
    logic [15:0] e_reg;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [2:0] w, r, s, input logic ss, pl, pi, ps, il, rw,
                              input logic [3:0] op, input logic [15:0] rd, input logic [2:0] chk,
                              input logic [15:0] e_pc, e_ir, input logic [2:0] e_nzc,
                              input logic [15:0] e_reg);
    vec_t v;
    v.w = w; v.r = r; v.s = s; v.s_sel = ss; v.pc_ld = pl; v.pc_inc = pi; v.pc_sel = ps;
    v.ir_ld = il; v.rw_en = rw; v.op = op; v.rd = rd; v.chk = chk; v.e_pc = e_pc;
    v.e_ir = e_ir; v.e_nzc = e_nzc; v.e_reg = e_reg;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    W_Adr = 3'd0; R_Adr = 3'd0; S_Adr = 3'd0;
    adr_sel = 1'b0; s_sel = 1'b0; pc_ld = 1'b0; pc_inc = 1'b0; pc_sel = 1'b0;
    ir_ld = 1'b0; mw_en = 1'b0; rw_en = 1'b0; alu_op = 4'b0000; mem_rdata = 16'h0000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // LDI: s_sel=1, rw_en=1, pc_inc=1.  Flags are {N,Z,C}.
    vq.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 4'h0, 16'h7FFF, 1, 16'h0002, 16'hE0C8, 3'b000, 16'h7FFF));
    vq.push_back(mk(2, 0, 0, 1, 0, 1, 0, 0, 1, 4'h0, 16'h0001, 2, 16'h0003, 16'hE0C8, 3'b000, 16'h0001));
    vq.push_back(mk(3, 1, 2, 0, 0, 0, 0, 0, 1, 4'h4, 16'h0000, 3, 16'h0003, 16'hE0C8, 3'b100, 16'h8000));
    vq.push_back(mk(4, 0, 0, 1, 0, 1, 0, 0, 1, 4'h0, 16'h0005, 4, 16'h0004, 16'hE0C8, 3'b100, 16'h0005));
    vq.push_back(mk(5, 0, 0, 1, 0, 1, 0, 0, 1, 4'h0, 16'h0005, 5, 16'h0005, 16'hE0C8, 3'b100, 16'h0005));
    vq.push_back(mk(4, 4, 5, 0, 0, 0, 0, 0, 0, 4'h5, 16'h0000, 4, 16'h0005, 16'hE0C8, 3'b010, 16'h0005));
    vq.push_back(mk(4, 0, 0, 1, 0, 1, 0, 0, 1, 4'h0, 16'h0003, 4, 16'h0006, 16'hE0C8, 3'b010, 16'h0003));
    vq.push_back(mk(4, 4, 5, 0, 0, 0, 0, 0, 0, 4'h5, 16'h0000, 4, 16'h0006, 16'hE0C8, 3'b101, 16'h0003));
    vq.push_back(mk(6, 0, 0, 1, 0, 1, 0, 0, 1, 4'h0, 16'h8001, 6, 16'h0007, 16'hE0C8, 3'b101, 16'h8001));
    vq.push_back(mk(6, 6, 0, 0, 0, 0, 0, 0, 1, 4'h7, 16'h0000, 6, 16'h0007, 16'hE0C8, 3'b001, 16'h0002));
    vq.push_back(mk(6, 0, 0, 1, 0, 1, 0, 0, 1, 4'h0, 16'h0001, 6, 16'h0008, 16'hE0C8, 3'b001, 16'h0001));
    vq.push_back(mk(6, 6, 0, 0, 0, 0, 0, 0, 1, 4'h6, 16'h0000, 6, 16'h0008, 16'hE0C8, 3'b011, 16'h0000));
    vq.push_back(mk(7, 0, 0, 1, 0, 1, 0, 0, 1, 4'h0, 16'hFFFF, 7, 16'h0009, 16'hE0C8, 3'b011, 16'hFFFF));
    vq.push_back(mk(0, 7, 0, 0, 0, 0, 0, 0, 1, 4'h3, 16'h0000, 0, 16'h0009, 16'hE0C8, 3'b100, 16'hFFFE));
    vq.push_back(mk(7, 7, 0, 0, 0, 0, 0, 0, 1, 4'h2, 16'h0000, 7, 16'h0009, 16'hE0C8, 3'b011, 16'h0000));
    vq.push_back(mk(5, 1, 0, 0, 0, 0, 0, 0, 1, 4'h0, 16'h0000, 5, 16'h0009, 16'hE0C8, 3'b011, 16'h7FFF));
    vq.push_back(mk(5, 2, 0, 0, 0, 0, 0, 0, 1, 4'hF, 16'h0000, 5, 16'h0009, 16'hE0C8, 3'b011, 16'h0001));
    vq.push_back(mk(4, 0, 0, 1, 0, 1, 0, 0, 1, 4'h0, 16'h0010, 4, 16'h000A, 16'hE0C8, 3'b011, 16'h0010));
    vq.push_back(mk(0, 4, 0, 0, 1, 0, 1, 0, 0, 4'h0, 16'h0000, 4, 16'h0010, 16'hE0C8, 3'b011, 16'h0010));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'h0, 16'h01FE, 0, 16'h0010, 16'h01FE, 3'b011, 16'hFFFE));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 4'h0, 16'h0000, 0, 16'h000E, 16'h01FE, 3'b011, 16'hFFFE));
    vq.push_back(mk(2, 0, 0, 1, 0, 1, 0, 0, 1, 4'h0, 16'h1234, 2, 16'h000F, 16'h01FE, 3'b011, 16'h1234));
    vq.push_back(mk(0, 2, 0, 0, 1, 1, 1, 0, 0, 4'h0, 16'h0000, 2, 16'h1234, 16'h01FE, 3'b011, 16'h1234));
    vq.push_back(mk(3, 0, 0, 1, 0, 1, 0, 0, 1, 4'h0, 16'hFFFF, 3, 16'h1235, 16'h01FE, 3'b011, 16'hFFFF));
    vq.push_back(mk(0, 3, 0, 0, 1, 0, 1, 0, 0, 4'h0, 16'h0000, 3, 16'hFFFF, 16'h01FE, 3'b011, 16'hFFFF));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0, 16'h0000, 3, 16'h0000, 16'h01FE, 3'b011, 16'hFFFF));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 4'h0, 16'h1234, 0, 16'h0001, 16'h1234, 3'b011, 16'hFFFE));

    // Reset state, then FETCH out of reset.
    idle();
    reset = 1'b0;
    mem_rdata = 16'hE0C8; ir_ld = 1'b1; pc_inc = 1'b1;
    #2;
    check("reset_pc", pc, 16'h0000);
    check("reset_ir", IR, 16'h0000);
    check("reset_flags", {13'd0, N, Z, C}, 16'h0000);
    check("reset_mem_addr", mem_addr, 16'h0000);
    check("reset_mem_we", {15'd0, mem_we}, 16'h0000);
    #1 reset = 1'b1;
    tick();
    check("fetch_ir", IR, 16'hE0C8);
    check("fetch_pc", pc, 16'h0001);

    foreach (vq[i]) begin
      vec_t v;
      v = vq[i];
      idle();
      W_Adr = v.w; R_Adr = v.r; S_Adr = v.s; s_sel = v.s_sel; pc_ld = v.pc_ld;
      pc_inc = v.pc_inc; pc_sel = v.pc_sel; ir_ld = v.ir_ld; rw_en = v.rw_en;
      alu_op = v.op; mem_rdata = v.rd;
      tick();
      idle();
      S_Adr = v.chk;
      #1;
      check($sformatf("vec%0d_pc", i), pc, v.e_pc);
      check($sformatf("vec%0d_mem_addr", i), mem_addr, v.e_pc);
      check($sformatf("vec%0d_ir", i), IR, v.e_ir);
      check($sformatf("vec%0d_nzc", i), {13'd0, N, Z, C}, {13'd0, v.e_nzc});
      check($sformatf("vec%0d_reg%0d", i, v.chk), mem_wdata, v.e_reg);
    end

    // STO: address from R6, data from R7.
    idle(); W_Adr = 3'd6; s_sel = 1'b1; rw_en = 1'b1; pc_inc = 1'b1; mem_rdata = 16'h0040;
    tick();
    idle(); W_Adr = 3'd7; s_sel = 1'b1; rw_en = 1'b1; pc_inc = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    idle(); adr_sel = 1'b1; R_Adr = 3'd6; S_Adr = 3'd7; mw_en = 1'b1;
    #1;
    check("sto_addr", mem_addr, 16'h0040);
    check("sto_wdata", mem_wdata, 16'hBEEF);
    check("sto_we", {15'd0, mem_we}, 16'h0001);
    tick();

    // Read during write to the same register sees the old value until the edge.
    idle(); W_Adr = 3'd5; S_Adr = 3'd5; s_sel = 1'b1; rw_en = 1'b1; mem_rdata = 16'hAAAA;
    #1;
    check("nobypass_old", mem_wdata, 16'h0001);
    tick();
    check("nobypass_new", mem_wdata, 16'hAAAA);

    // Mid-cycle reset clears state at once; the pending R0 write is lost.
    idle(); W_Adr = 3'd0; S_Adr = 3'd0; s_sel = 1'b1; rw_en = 1'b1; mem_rdata = 16'h5555;
    #2 reset = 1'b0;
    #1;
    check("async_pc", pc, 16'h0000);
    check("async_ir", IR, 16'h0000);
    check("async_flags", {13'd0, N, Z, C}, 16'h0000);
    check("async_r0", mem_wdata, 16'h0000);
    tick();
    reset = 1'b1;
    idle();
    #1;
    check("lost_write_r0", mem_wdata, 16'h0000);
    check("post_reset_pc", pc, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_execution_unit.md
Name: cpu_execution_unit

Overview:
Datapath slave of the 16-bit RISC control unit. It consumes the control word (register addresses, mux selects, PC/IR controls, write enables, alu_op) and returns IR and the registered N/Z/C flags. It holds PC, IR, an 8x16 register file, the ALU and the flag register. It drives the single unified memory port (asynchronous read, synchronous write).

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  asynchronous, active-low reset
W_Adr  in  3  register-file write address
R_Adr  in  3  register-file read port R address
S_Adr  in  3  register-file read port S address
adr_sel  in  1  mem_addr select: 0=PC, 1=reg[R_Adr]
s_sel  in  1  register write-data select: 0=ALU result, 1=mem_rdata
pc_ld  in  1  load PC with jump target
pc_inc  in  1  PC <= PC+1
pc_sel  in  1  jump target select: 0=PC+sext(IR[8:0]), 1=reg[R_Adr]
ir_ld  in  1  IR <= mem_rdata
mw_en  in  1  memory write enable
rw_en  in  1  register-file write enable
alu_op  in  4  ALU operation
mem_rdata  in  16  memory read data, combinational from mem_addr
IR  out  16  instruction register
N, Z, C  out  1 each  registered flags
mem_addr  out  16  memory address
mem_wdata  out  16  memory write data = reg[S_Adr]
mem_we  out  1  = mw_en
pc  out  16  program counter (debug)

Behaviour:
- Reset (reset=0, async): PC=RESET_PC, IR=0, N=Z=C=0, all 8 registers=0. Resulting outputs: mem_addr=RESET_PC when adr_sel=0; mem_we=mw_en (0 under CU reset state).
- Reset asserted mid-instruction: aborts immediately. A write pending on the next edge is lost.
- Register file: 2 combinational read ports (R, S) and 1 synchronous write port. On posedge with rw_en=1: reg[W_Adr] <= (s_sel ? mem_rdata : alu_y).
- Read during write to the same address returns the old value; there is no bypass. R0 is an ordinary register.
- ALU, combinational, 17-bit internal. A=reg[R_Adr], B=reg[S_Adr].
  - 0000: y=A, pass.
  - 0010: A+1, c=carry out.
  - 0011: A-1, c=borrow (A==0).
  - 0100: A+B, c=carry bit16.
  - 0101: A-B, c=borrow (A<B unsigned).
  - 0110: A>>1 logical, c=A[0].
  - 0111: A<<1, c=A[15].
  - Other codes: y=A.
- Flags: updated on posedge only when alu_op is in 0010..0111, independent of rw_en (CMP updates flags without writing). N<=y[15], Z<=(y==0), C<=c. Otherwise flags hold.
- PC priority: pc_ld > pc_inc > hold. pc_ld: PC <= pc_sel ? reg[R_Adr] : PC+sext(IR[8:0]). All PC arithmetic wraps modulo 2^16 (16'hFFFF+1 = 0).
- IR: on posedge with ir_ld=1, IR <= mem_rdata.
- Same-edge events: FETCH (ir_ld+pc_inc) loads IR with the word at the old PC. LDI (s_sel+pc_inc, adr_sel=0) writes the word at the old PC into W, then PC+1.
- Memory: mem_addr = adr_sel ? reg[R_Adr] : PC. mem_wdata = reg[S_Adr]. The memory captures the write at the posedge where mem_we=1.
- Latency: every control word is fully executed in the one cycle it is presented.

Decomposition:
- Shared package cpu_defs_pkg:
  - ALU_PASS=4'b0000, ALU_INC=4'b0010, ALU_DEC=4'b0011, ALU_ADD=4'b0100, ALU_SUB=4'b0101, ALU_SHR=4'b0110, ALU_SHL=4'b0111.
  - Opcode constants 7'h70..7'h7f, shared with the control unit.
- One sub-module, cpu_alu: combinational; inputs a, b, alu_op; outputs y, c, upd_flags.
- Register file and PC/IR/flags stay inline.

Test Plan:
1. Reset release with mem_rdata=16'hE0C8, ir_ld=1, pc_inc=1 -> after 1 edge IR=16'hE0C8, pc=1. Assert reset mid-cycle -> pc, IR and flags return to 0 immediately, without waiting for a clock edge.
2. LDI: adr_sel=0, s_sel=1, rw_en=1, W_Adr=1, pc_inc=1, mem_rdata=16'h7FFF -> R1=16'h7FFF, pc+1. Then ADD with R1=16'h7FFF, R2=1, W=3 -> R3=16'h8000, N=1, Z=0, C=0.
3. SUB/CMP: R4=5, R5=5, alu_op=0101, rw_en=0 -> Z=1, C=0, R registers unchanged. Then R4=3, R5=5 -> N=1, C=1.
4. Shifts and edges:
   - SHL on 16'h8001 -> 16'h0002, C=1.
   - SHR on 16'h0001 -> 0, Z=1, C=1.
   - INC on 16'hFFFF -> 0, Z=1, C=1.
   - A following MOV leaves the flags unchanged.
5. STO: R6=16'h0040, R7=16'hBEEF, adr_sel=1, R_Adr=6, S_Adr=7, mw_en=1 -> mem_addr=16'h0040, mem_wdata=16'hBEEF, mem_we=1.
6. Jumps:
   - pc=16'h0010, IR[8:0]=9'h1FE, pc_ld=1, pc_sel=0 -> pc=16'h000E.
   - pc_ld and pc_inc together -> the load wins.
   - pc_sel=1 with R_Adr=2, R2=16'h1234 -> pc=16'h1234.
